// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- memory-access stage between execute and writeback.
//
// Performs loads, stores and RV32A atomics (LR.W, SC.W, AMO*.W) over a
// single-port request/ack data-memory interface. It aligns and extends load
// data, sequences the atomic read-modify-write and keeps the LR/SC
// reservation. Each completed instruction is registered into the writeback
// bundle; upstream is stalled while a memory transaction is outstanding.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ex_*               instruction presented by execute
//   flush              turn this cycle's writeback into a bubble (stall_o=0 only)
//   stall_o            hold execute and earlier stages
//   mem_req/mem_we     data-memory request / write
//   mem_addr           word-aligned address
//   mem_wdata/mem_mask lane-positioned write data and byte enables
//   mem_rdata/mem_ack  read data and transaction-complete strobe
//   wb_out             registered bundle towards writeback
// -----------------------------------------------------------------------------

package wb_stage_pkg;

  typedef struct packed {
    logic [31:0] opr_res;
    logic [31:0] csr_rdata;
    logic [31:0] pc4;
    logic [31:0] lsu_rdata;
    logic [4:0]  rd;
    logic        rf_en;
    logic [1:0]  wb_sel;
    logic        amo_mem_wr_req;
    logic [3:0]  mask;
    logic [31:0] core_out_mem_addr_in;
    logic [31:0] core_out_mem_data_in;
  } wb_stage_in_t;

endpackage

module mem_stage #(
  parameter int XLEN = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ex_valid,
  input  logic [XLEN-1:0]            ex_opr_res,
  input  logic [XLEN-1:0]            ex_rs2,
  input  logic [XLEN-1:0]            ex_csr_rdata,
  input  logic [XLEN-1:0]            ex_pc4,
  input  logic [4:0]                 ex_rd,
  input  logic                       ex_rf_en,
  input  logic [1:0]                 ex_wb_sel,
  input  logic                       ex_mem_rd,
  input  logic                       ex_mem_wr,
  input  logic [2:0]                 ex_funct3,
  input  logic                       ex_amo,
  input  logic [4:0]                 ex_amo_op,
  input  logic                       flush,
  output logic                       stall_o,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_mask,
  input  logic [31:0]                mem_rdata,
  input  logic                       mem_ack,
  output wb_stage_pkg::wb_stage_in_t wb_out
);

  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_AMO_RD = 2'd2,
    ST_AMO_WR = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Helper functions
  // ---------------------------------------------------------------------------

  // Pick the addressed lane out of the read word and extend it.
  function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                             input logic [1:0]  off,
                                             input logic [2:0]  f3);
    logic [31:0] byte_lane;
    logic [15:0] half_lane;
    logic [31:0] res;
    byte_lane = rdata >> {off, 3'b000};
    // Halfwords only look at addr[1]; addr[0] is ignored.
    half_lane = off[1] ? rdata[31:16] : rdata[15:0];
    case (f3)
      3'b000:  res = {{24{byte_lane[7]}}, byte_lane[7:0]};
      3'b100:  res = {24'd0, byte_lane[7:0]};
      3'b001:  res = {{16{half_lane[15]}}, half_lane};
      3'b101:  res = {16'd0, half_lane};
      default: res = rdata;
    endcase
    return res;
  endfunction

  // Byte enables for a plain load/store of the given size.
  function automatic logic [3:0] size_mask(input logic [1:0] off,
                                           input logic [2:0] f3);
    logic [3:0] res;
    case (f3[1:0])
      2'b00:   res = 4'b0001 << off;
      2'b01:   res = off[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  // Replicate store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_data(input logic [31:0] rs2,
                                             input logic [2:0]  f3);
    logic [31:0] res;
    case (f3[1:0])
      2'b00:   res = {4{rs2[7:0]}};
      2'b01:   res = {2{rs2[15:0]}};
      default: res = rs2;
    endcase
    return res;
  endfunction

  // New memory value for a read-modify-write atomic.
  function automatic logic [31:0] amo_alu(input logic [31:0] old_val,
                                          input logic [31:0] rs2,
                                          input logic [4:0]  op);
    logic [31:0] res;
    case (op)
      AMO_SWAP: res = rs2;
      AMO_ADD:  res = old_val + rs2;
      AMO_XOR:  res = old_val ^ rs2;
      AMO_AND:  res = old_val & rs2;
      AMO_OR:   res = old_val | rs2;
      AMO_MIN:  res = ($signed(old_val) < $signed(rs2)) ? old_val : rs2;
      AMO_MAX:  res = ($signed(old_val) > $signed(rs2)) ? old_val : rs2;
      AMO_MINU: res = (old_val < rs2) ? old_val : rs2;
      AMO_MAXU: res = (old_val > rs2) ? old_val : rs2;
      default:  res = old_val;
    endcase
    return res;
  endfunction

  // ---------------------------------------------------------------------------
  // State and instruction holding registers
  // ---------------------------------------------------------------------------
  state_t      state_r;
  state_t      state_nxt_s;

  logic [31:0] hold_opr_res_r;
  logic [31:0] hold_rs2_r;
  logic [31:0] hold_csr_rdata_r;
  logic [31:0] hold_pc4_r;
  logic [4:0]  hold_rd_r;
  logic        hold_rf_en_r;
  logic [1:0]  hold_wb_sel_r;
  logic        hold_mem_rd_r;
  logic        hold_mem_wr_r;
  logic [2:0]  hold_funct3_r;
  logic        hold_amo_r;
  logic [4:0]  hold_amo_op_r;

  logic [31:0] amo_old_r;
  logic        resv_valid_r;
  logic [29:0] resv_addr_r;

  // The instruction being worked on: live from execute in IDLE, otherwise the
  // copy taken when the transaction started.
  logic        in_idle_s;
  logic [31:0] cur_opr_res_s;
  logic [31:0] cur_rs2_s;
  logic [31:0] cur_csr_rdata_s;
  logic [31:0] cur_pc4_s;
  logic [4:0]  cur_rd_s;
  logic        cur_rf_en_s;
  logic [1:0]  cur_wb_sel_s;
  logic        cur_mem_rd_s;
  logic        cur_mem_wr_s;
  logic [2:0]  cur_funct3_s;
  logic        cur_amo_s;
  logic [4:0]  cur_amo_op_s;

  assign in_idle_s       = (state_r == ST_IDLE);
  assign cur_opr_res_s   = in_idle_s ? ex_opr_res   : hold_opr_res_r;
  assign cur_rs2_s       = in_idle_s ? ex_rs2       : hold_rs2_r;
  assign cur_csr_rdata_s = in_idle_s ? ex_csr_rdata : hold_csr_rdata_r;
  assign cur_pc4_s       = in_idle_s ? ex_pc4       : hold_pc4_r;
  assign cur_rd_s        = in_idle_s ? ex_rd        : hold_rd_r;
  assign cur_rf_en_s     = in_idle_s ? ex_rf_en     : hold_rf_en_r;
  assign cur_wb_sel_s    = in_idle_s ? ex_wb_sel    : hold_wb_sel_r;
  assign cur_mem_rd_s    = in_idle_s ? ex_mem_rd    : hold_mem_rd_r;
  assign cur_mem_wr_s    = in_idle_s ? ex_mem_wr    : hold_mem_wr_r;
  assign cur_funct3_s    = in_idle_s ? ex_funct3    : hold_funct3_r;
  assign cur_amo_s       = in_idle_s ? ex_amo       : hold_amo_r;
  assign cur_amo_op_s    = in_idle_s ? ex_amo_op    : hold_amo_op_r;

  // Decode. ex_amo overrides the plain load/store flags.
  logic is_lr_s;
  logic is_sc_s;
  logic is_amo_rmw_s;
  logic is_load_s;
  logic is_store_s;
  logic resv_hit_s;
  logic sc_ok_s;
  logic issue_s;

  assign is_lr_s      = cur_amo_s & (cur_amo_op_s == AMO_LR);
  assign is_sc_s      = cur_amo_s & (cur_amo_op_s == AMO_SC);
  assign is_amo_rmw_s = cur_amo_s & ~is_lr_s & ~is_sc_s;
  assign is_load_s    = ~cur_amo_s & cur_mem_rd_s;
  assign is_store_s   = ~cur_amo_s & cur_mem_wr_s;
  assign resv_hit_s   = resv_valid_r & (resv_addr_r == cur_opr_res_s[31:2]);
  assign sc_ok_s      = is_sc_s & resv_hit_s;
  assign issue_s      = in_idle_s & ex_valid & ~flush;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  logic mem_req_s;
  logic mem_we_s;
  logic done_s;
  logic old_cap_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, bus request and completion strobe.
  always_comb begin
    state_nxt_s = state_r;
    mem_req_s   = 1'b0;
    mem_we_s    = 1'b0;
    done_s      = 1'b0;
    old_cap_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!issue_s) begin
          state_nxt_s = ST_IDLE;
        end else if (is_load_s || is_store_s || is_lr_s || sc_ok_s) begin
          mem_req_s = 1'b1;
          mem_we_s  = is_store_s | sc_ok_s;
          if (mem_ack) begin
            done_s = 1'b1;
          end else begin
            state_nxt_s = ST_ACCESS;
          end
        end else if (is_amo_rmw_s) begin
          mem_req_s = 1'b1;
          if (mem_ack) begin
            old_cap_s   = 1'b1;
            state_nxt_s = ST_AMO_WR;
          end else begin
            state_nxt_s = ST_AMO_RD;
          end
        end else begin
          // ALU op or failed SC: no bus access, completes now.
          done_s = 1'b1;
        end
      end
      ST_ACCESS: begin
        mem_req_s = 1'b1;
        mem_we_s  = is_store_s | sc_ok_s;
        if (mem_ack) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_AMO_RD: begin
        mem_req_s = 1'b1;
        if (mem_ack) begin
          old_cap_s   = 1'b1;
          state_nxt_s = ST_AMO_WR;
        end else begin
          state_nxt_s = ST_AMO_RD;
        end
      end
      ST_AMO_WR: begin
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
        if (mem_ack) begin
          done_s      = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_AMO_WR;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // The AMO read completes without retiring, so stall covers it too.
  assign stall_o = mem_req_s & ~done_s;

  // Capture the instruction while idle so it stays stable across the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_opr_res_r   <= 32'd0;
      hold_rs2_r       <= 32'd0;
      hold_csr_rdata_r <= 32'd0;
      hold_pc4_r       <= 32'd0;
      hold_rd_r        <= 5'd0;
      hold_rf_en_r     <= 1'b0;
      hold_wb_sel_r    <= 2'd0;
      hold_mem_rd_r    <= 1'b0;
      hold_mem_wr_r    <= 1'b0;
      hold_funct3_r    <= 3'd0;
      hold_amo_r       <= 1'b0;
      hold_amo_op_r    <= 5'd0;
    end else if (in_idle_s) begin
      hold_opr_res_r   <= ex_opr_res;
      hold_rs2_r       <= ex_rs2;
      hold_csr_rdata_r <= ex_csr_rdata;
      hold_pc4_r       <= ex_pc4;
      hold_rd_r        <= ex_rd;
      hold_rf_en_r     <= ex_rf_en;
      hold_wb_sel_r    <= ex_wb_sel;
      hold_mem_rd_r    <= ex_mem_rd;
      hold_mem_wr_r    <= ex_mem_wr;
      hold_funct3_r    <= ex_funct3;
      hold_amo_r       <= ex_amo;
      hold_amo_op_r    <= ex_amo_op;
    end else begin
      hold_opr_res_r   <= hold_opr_res_r;
    end
  end

  // Old memory value of a read-modify-write atomic.
  always_ff @(posedge clk) begin
    if (rst) begin
      amo_old_r <= 32'd0;
    end else if (old_cap_s) begin
      amo_old_r <= mem_rdata;
    end else begin
      amo_old_r <= amo_old_r;
    end
  end

  // LR/SC reservation: set by LR, cleared by any SC or a write to the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      resv_valid_r <= 1'b0;
      resv_addr_r  <= 30'd0;
    end else if (done_s && is_lr_s) begin
      resv_valid_r <= 1'b1;
      resv_addr_r  <= cur_opr_res_s[31:2];
    end else if (done_s && is_sc_s) begin
      resv_valid_r <= 1'b0;
    end else if (done_s && mem_we_s && resv_hit_s) begin
      resv_valid_r <= 1'b0;
    end else begin
      resv_valid_r <= resv_valid_r;
    end
  end

  // ---------------------------------------------------------------------------
  // Bus datapath
  // ---------------------------------------------------------------------------
  logic [3:0]  bus_mask_s;
  logic [31:0] bus_wdata_s;
  logic [31:0] word_addr_s;

  assign word_addr_s = {cur_opr_res_s[31:2], 2'b00};

  // Write data and byte enables; atomics always use the full word.
  always_comb begin
    bus_mask_s  = 4'b1111;
    bus_wdata_s = cur_rs2_s;
    if (is_amo_rmw_s) begin
      bus_wdata_s = amo_alu(amo_old_r, cur_rs2_s, cur_amo_op_s);
    end else if (cur_amo_s) begin
      bus_wdata_s = cur_rs2_s;
    end else begin
      bus_mask_s  = size_mask(cur_opr_res_s[1:0], cur_funct3_s);
      bus_wdata_s = store_data(cur_rs2_s, cur_funct3_s);
    end
  end

  assign mem_req   = mem_req_s;
  assign mem_we    = mem_we_s;
  assign mem_addr  = mem_req_s ? word_addr_s : 32'd0;
  assign mem_mask  = mem_req_s ? bus_mask_s : 4'd0;
  assign mem_wdata = (mem_req_s && mem_we_s) ? bus_wdata_s : 32'd0;

  // ---------------------------------------------------------------------------
  // Writeback bundle
  // ---------------------------------------------------------------------------
  logic [31:0]                lsu_res_s;
  wb_stage_pkg::wb_stage_in_t wb_nxt_s;

  // Value returned to rd for memory instructions.
  always_comb begin
    lsu_res_s = 32'd0;
    if (is_load_s) begin
      lsu_res_s = load_align(mem_rdata, cur_opr_res_s[1:0], cur_funct3_s);
    end else if (is_lr_s) begin
      lsu_res_s = mem_rdata;
    end else if (is_amo_rmw_s) begin
      lsu_res_s = amo_old_r;
    end else if (is_sc_s) begin
      lsu_res_s = {31'd0, ~sc_ok_s};
    end else begin
      lsu_res_s = 32'd0;
    end
  end

  // Next writeback entry; anything that does not retire is a bubble.
  always_comb begin
    wb_nxt_s = '0;
    if (done_s) begin
      wb_nxt_s.opr_res   = cur_opr_res_s;
      wb_nxt_s.csr_rdata = cur_csr_rdata_s;
      wb_nxt_s.pc4       = cur_pc4_s;
      wb_nxt_s.lsu_rdata = lsu_res_s;
      wb_nxt_s.rd        = cur_rd_s;
      wb_nxt_s.rf_en     = cur_rf_en_s & ~is_store_s;
      wb_nxt_s.wb_sel    = cur_wb_sel_s;
      if (is_amo_rmw_s || sc_ok_s) begin
        wb_nxt_s.amo_mem_wr_req       = 1'b1;
        wb_nxt_s.mask                 = bus_mask_s;
        wb_nxt_s.core_out_mem_addr_in = word_addr_s;
        wb_nxt_s.core_out_mem_data_in = bus_wdata_s;
      end else begin
        wb_nxt_s.amo_mem_wr_req       = 1'b0;
        wb_nxt_s.mask                 = 4'd0;
        wb_nxt_s.core_out_mem_addr_in = 32'd0;
        wb_nxt_s.core_out_mem_data_in = 32'd0;
      end
    end else begin
      wb_nxt_s = '0;
    end
  end

  // Writeback register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_out <= '0;
    end else begin
      wb_out <= wb_nxt_s;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- scoreboard bench for mem_stage. Expected writeback entries
// are queued when an instruction is driven and compared when the stage
// retires a non-bubble entry. A small word memory with a programmable ack
// delay answers the data-memory port.
// -----------------------------------------------------------------------------
module tb_mem_stage;
  import wb_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_opr_res, ex_rs2, ex_csr_rdata, ex_pc4;
  logic [4:0]  ex_rd;
  logic        ex_rf_en;
  logic [1:0]  ex_wb_sel;
  logic        ex_mem_rd, ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic        ex_amo;
  logic [4:0]  ex_amo_op;
  logic        flush;
  logic        stall_o, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_mask;
  logic        mem_ack;
  wb_stage_in_t wb_out;

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid),
    .ex_opr_res(ex_opr_res), .ex_rs2(ex_rs2), .ex_csr_rdata(ex_csr_rdata),
    .ex_pc4(ex_pc4), .ex_rd(ex_rd), .ex_rf_en(ex_rf_en), .ex_wb_sel(ex_wb_sel),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr), .ex_funct3(ex_funct3),
    .ex_amo(ex_amo), .ex_amo_op(ex_amo_op), .flush(flush), .stall_o(stall_o),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .wb_out(wb_out)
  );

  int           n_vec = 0;
  int           n_err = 0;
  wb_stage_in_t exp_q[$];
  logic [31:0]  mem_model [0:255];
  int           ack_wait;
  int           req_cnt;
  logic         last_stall;
  int           stall_cycles;
  logic         seen_req;
  int           wr_cnt;
  logic [31:0]  wr_addr, wr_data;
  logic [3:0]   wr_mask;
  string        cur_name;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic wb_stage_in_t make_exp(
      input logic [31:0] opr, input logic [4:0] rd, input logic rf_en,
      input logic [31:0] lsu, input logic amo_wr, input logic [3:0] mask,
      input logic [31:0] waddr, input logic [31:0] wdata);
    wb_stage_in_t e;
    e = '0;
    e.opr_res              = opr;
    e.csr_rdata            = 32'hC5C5_0000;
    e.pc4                  = opr + 32'd4;
    e.lsu_rdata            = lsu;
    e.rd                   = rd;
    e.rf_en                = rf_en;
    e.wb_sel               = 2'b01;
    e.amo_mem_wr_req       = amo_wr;
    e.mask                 = mask;
    e.core_out_mem_addr_in = waddr;
    e.core_out_mem_data_in = wdata;
    return e;
  endfunction

  // Compare a retired writeback entry with the head of the scoreboard.
  task automatic check_wb();
    wb_stage_in_t e;
    if (wb_out != '0) begin
      if (exp_q.size() == 0) begin
        check_val({cur_name, ".unexpected_wb"}, 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val({cur_name, ".opr_res"}, wb_out.opr_res, e.opr_res);
        check_val({cur_name, ".pc4"}, wb_out.pc4, e.pc4);
        check_val({cur_name, ".lsu_rdata"}, wb_out.lsu_rdata, e.lsu_rdata);
        check_val({cur_name, ".rd"}, {27'd0, wb_out.rd}, {27'd0, e.rd});
        check_val({cur_name, ".rf_en"}, {31'd0, wb_out.rf_en}, {31'd0, e.rf_en});
        check_val({cur_name, ".amo_wr"}, {31'd0, wb_out.amo_mem_wr_req},
                  {31'd0, e.amo_mem_wr_req});
        check_val({cur_name, ".mask"}, {28'd0, wb_out.mask}, {28'd0, e.mask});
        check_val({cur_name, ".wr_addr"}, wb_out.core_out_mem_addr_in,
                  e.core_out_mem_addr_in);
        check_val({cur_name, ".wr_data"}, wb_out.core_out_mem_data_in,
                  e.core_out_mem_data_in);
      end
    end
  endtask

  // One clock: answer the memory port, update the model, check writeback.
  task automatic run_cycle();
    #1;
    mem_ack   = mem_req && (req_cnt >= ack_wait);
    mem_rdata = mem_req ? mem_model[mem_addr[9:2]] : 32'd0;
    #1;
    last_stall = stall_o;
    if (stall_o) stall_cycles++;
    if (mem_req) seen_req = 1'b1;
    if (mem_req && mem_ack && mem_we) begin
      wr_cnt++;
      wr_addr = mem_addr;
      wr_data = mem_wdata;
      wr_mask = mem_mask;
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) mem_model[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
    end
    req_cnt = (mem_req && !mem_ack) ? req_cnt + 1 : 0;
    @(posedge clk);
    @(negedge clk);
    check_wb();
  endtask

  // Drive one instruction and hold it until the stage stops stalling.
  task automatic do_instr(input string name, input logic [31:0] opr,
                          input logic [31:0] rs2, input logic [4:0] rd,
                          input logic rf_en, input logic mrd, input logic mwr,
                          input logic [2:0] f3, input logic amo,
                          input logic [4:0] aop, input int wait_n,
                          input wb_stage_in_t exp);
    int cyc;
    cur_name     = name;
    ack_wait     = wait_n;
    stall_cycles = 0;
    seen_req     = 1'b0;
    wr_cnt       = 0;
    ex_valid     = 1'b1;
    ex_opr_res   = opr;
    ex_rs2       = rs2;
    ex_csr_rdata = 32'hC5C5_0000;
    ex_pc4       = opr + 32'd4;
    ex_rd        = rd;
    ex_rf_en     = rf_en;
    ex_wb_sel    = 2'b01;
    ex_mem_rd    = mrd;
    ex_mem_wr    = mwr;
    ex_funct3    = f3;
    ex_amo       = amo;
    ex_amo_op    = aop;
    exp_q.push_back(exp);
    run_cycle();
    cyc = 1;
    while (last_stall && cyc < 30) begin
      run_cycle();
      cyc++;
    end
    if (last_stall) check_val({name, ".timeout"}, 32'd1, 32'd0);
    ex_valid  = 1'b0;
    ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0;
    ex_amo    = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 32'd0;
    mem_model[8'h10] = 32'd5;            // 0x40
    mem_model[8'h14] = 32'hFFFF_FFFD;    // 0x50
    mem_model[8'h18] = 32'hFFFF_FFFD;    // 0x60
    mem_model[8'h20] = 32'h0000_0077;    // 0x80
    mem_model[8'h40] = 32'h80FF_FF7F;    // 0x100
    rst = 1'b1; flush = 1'b0; ex_valid = 1'b0;
    ex_opr_res = 32'd0; ex_rs2 = 32'd0; ex_csr_rdata = 32'd0; ex_pc4 = 32'd0;
    ex_rd = 5'd0; ex_rf_en = 1'b0; ex_wb_sel = 2'd0; ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0; ex_funct3 = 3'd0; ex_amo = 1'b0; ex_amo_op = 5'd0;
    mem_ack = 1'b0; mem_rdata = 32'd0; ack_wait = 0; req_cnt = 0;
    cur_name = "reset";

    run_cycle();
    run_cycle();
    check_val("reset.wb_zero", {31'd0, wb_out != '0}, 32'd0);
    check_val("reset.mem_req", {31'd0, mem_req}, 32'd0);
    check_val("reset.stall", {31'd0, stall_o}, 32'd0);
    rst = 1'b0;
    run_cycle();

    // ALU op: one-cycle latency, never stalls.
    do_instr("alu", 32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 0,
             make_exp(32'h1234, 5'd5, 1'b1, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("alu.stall_cycles", stall_cycles, 32'd0);

    // Loads: sign/zero extension across lanes and wait states.
    do_instr("lb", 32'h103, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 2,
             make_exp(32'h103, 5'd7, 1'b1, 32'hFFFF_FF80, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("lb.stall_cycles", stall_cycles, 32'd2);
    do_instr("lbu", 32'h101, 32'd0, 5'd8, 1'b1, 1'b1, 1'b0, 3'b100, 1'b0, 5'd0, 0,
             make_exp(32'h101, 5'd8, 1'b1, 32'h0000_00FF, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("lbu.stall_cycles", stall_cycles, 32'd0);
    do_instr("lh", 32'h100, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 5'd0, 1,
             make_exp(32'h100, 5'd9, 1'b1, 32'hFFFF_FF7F, 1'b0, 4'd0, 32'd0, 32'd0));
    do_instr("lhu", 32'h103, 32'd0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b101, 1'b0, 5'd0, 0,
             make_exp(32'h103, 5'd10, 1'b1, 32'h0000_80FF, 1'b0, 4'd0, 32'd0, 32'd0));
    do_instr("lw", 32'h102, 32'd0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 5'd0, 0,
             make_exp(32'h102, 5'd11, 1'b1, 32'h80FF_FF7F, 1'b0, 4'd0, 32'd0, 32'd0));

    // Stores: lane masks and replicated data.
    do_instr("sh", 32'h202, 32'h0000_ABCD, 5'd0, 1'b0, 1'b0, 1'b1, 3'b001, 1'b0, 5'd0, 1,
             make_exp(32'h202, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("sh.addr", wr_addr, 32'h200);
    check_val("sh.mask", {28'd0, wr_mask}, 32'hC);
    check_val("sh.wdata", wr_data, 32'hABCD_ABCD);
    do_instr("sb", 32'h201, 32'h1234_565A, 5'd0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 5'd0, 0,
             make_exp(32'h201, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("sb.mask", {28'd0, wr_mask}, 32'h2);
    check_val("sb.wdata", wr_data, 32'h5A5A_5A5A);
    check_val("sb.mem", mem_model[8'h80], 32'hABCD_5A00);

    // Read-modify-write atomics.
    do_instr("amoadd", 32'h40, 32'd3, 5'd12, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00000, 1,
             make_exp(32'h40, 5'd12, 1'b1, 32'd5, 1'b1, 4'hF, 32'h40, 32'd8));
    check_val("amoadd.mem", mem_model[8'h10], 32'd8);
    check_val("amoadd.stall_cycles", stall_cycles, 32'd3);
    do_instr("amomin", 32'h50, 32'd2, 5'd13, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b10000, 0,
             make_exp(32'h50, 5'd13, 1'b1, 32'hFFFF_FFFD, 1'b1, 4'hF, 32'h50, 32'hFFFF_FFFD));
    do_instr("amominu", 32'h60, 32'd2, 5'd14, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b11000, 0,
             make_exp(32'h60, 5'd14, 1'b1, 32'hFFFF_FFFD, 1'b1, 4'hF, 32'h60, 32'd2));
    check_val("amominu.mem", mem_model[8'h18], 32'd2);

    // LR/SC pairs.
    do_instr("lr1", 32'h80, 32'd0, 5'd15, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00010, 1,
             make_exp(32'h80, 5'd15, 1'b1, 32'h77, 1'b0, 4'd0, 32'd0, 32'd0));
    do_instr("sc_ok", 32'h80, 32'h99, 5'd16, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00011, 1,
             make_exp(32'h80, 5'd16, 1'b1, 32'd0, 1'b1, 4'hF, 32'h80, 32'h99));
    check_val("sc_ok.mem", mem_model[8'h20], 32'h99);
    do_instr("sc_again", 32'h80, 32'h55, 5'd17, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00011, 0,
             make_exp(32'h80, 5'd17, 1'b1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("sc_again.no_req", {31'd0, seen_req}, 32'd0);
    do_instr("lr2", 32'h80, 32'd0, 5'd18, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00010, 0,
             make_exp(32'h80, 5'd18, 1'b1, 32'h99, 1'b0, 4'd0, 32'd0, 32'd0));
    do_instr("sw", 32'h80, 32'h11, 5'd0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 5'd0, 0,
             make_exp(32'h80, 5'd0, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0));
    do_instr("sc_after_sw", 32'h80, 32'h22, 5'd19, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00011, 0,
             make_exp(32'h80, 5'd19, 1'b1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("sc_after_sw.no_req", {31'd0, seen_req}, 32'd0);
    check_val("sc_after_sw.mem", mem_model[8'h20], 32'h11);

    // Flush while not stalled: bubble, no bus request.
    cur_name = "flush";
    seen_req = 1'b0;
    ex_valid = 1'b1; ex_mem_rd = 1'b1; ex_opr_res = 32'h100; ex_rf_en = 1'b1;
    flush = 1'b1;
    run_cycle();
    flush = 1'b0; ex_valid = 1'b0; ex_mem_rd = 1'b0;
    check_val("flush.no_req", {31'd0, seen_req}, 32'd0);
    run_cycle();

    // Reset in the middle of an AMO read drops the request and reservation.
    do_instr("lr3", 32'h80, 32'd0, 5'd20, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00010, 0,
             make_exp(32'h80, 5'd20, 1'b1, 32'h11, 1'b0, 4'd0, 32'd0, 32'd0));
    cur_name = "rst_amo";
    ack_wait = 1000;
    ex_valid = 1'b1; ex_amo = 1'b1; ex_amo_op = 5'b00000; ex_opr_res = 32'h40;
    ex_rs2 = 32'd7; ex_rd = 5'd21; ex_rf_en = 1'b1;
    run_cycle();
    run_cycle();
    check_val("rst_amo.stalled", {31'd0, last_stall}, 32'd1);
    rst = 1'b1; ex_valid = 1'b0; ex_amo = 1'b0;
    run_cycle();
    rst = 1'b0;
    #2;
    check_val("rst_amo.mem_req", {31'd0, mem_req}, 32'd0);
    check_val("rst_amo.stall", {31'd0, stall_o}, 32'd0);
    check_val("rst_amo.rf_en", {31'd0, wb_out.rf_en}, 32'd0);
    @(negedge clk);
    run_cycle();
    do_instr("sc_after_rst", 32'h80, 32'h33, 5'd22, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 5'b00011, 0,
             make_exp(32'h80, 5'd22, 1'b1, 32'd1, 1'b0, 4'd0, 32'd0, 32'd0));
    check_val("sc_after_rst.no_req", {31'd0, seen_req}, 32'd0);
    check_val("rst_amo.mem_kept", mem_model[8'h10], 32'd8);

    run_cycle();
    check_val("scoreboard.empty", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage between execute and writeback.
- Performs loads, stores and RV32A atomics (LR.W, SC.W, AMO*.W) over a single-port request/ack data-memory interface.
- Aligns and extends load data, runs the atomic read-modify-write sequence and keeps the LR/SC reservation.
- Registers each completed instruction into the wb_stage_pkg::wb_stage_in_t bundle; stalls upstream while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  execute presents a valid instruction.
- ex_opr_res  in  32  ALU result; effective address for memory ops.
- ex_rs2  in  32  store data / AMO operand.
- ex_csr_rdata, ex_pc4  in  32 each  passed through to writeback.
- ex_rd  in  5  destination register.
- ex_rf_en  in  1  register-file write enable.
- ex_wb_sel  in  2  writeback mux select, passed through.
- ex_mem_rd, ex_mem_wr  in  1 each  load / store.
- ex_funct3  in  3  size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ex_amo  in  1  atomic instruction.
- ex_amo_op  in  5  funct5: 00010 LR, 00011 SC, 00001 SWAP, 00000 ADD, 00100 XOR, 01100 AND, 01000 OR, 10000 MIN, 10100 MAX, 11000 MINU, 11100 MAXU.
- flush  in  1  replace this cycle's writeback with a bubble.
- stall_o  out  1  hold execute/earlier stages.
- mem_req  out  1  data-memory request.
- mem_we  out  1  write request.
- mem_addr  out  32  word-aligned address; bits [1:0] forced to 0.
- mem_wdata  out  32  lane-positioned write data.
- mem_mask  out  4  byte enables.
- mem_rdata  in  32  read data; valid when mem_ack is high.
- mem_ack  in  1  transaction complete; may assert in the same cycle as mem_req.
- wb_out  out  $bits(wb_stage_in_t)  registered bundle to the writeback stage.

Behaviour:
- Reset: wb_out all zeros (rf_en=0, amo_mem_wr_req=0); mem_req=0; FSM in IDLE; reservation invalid. Reset mid-transaction drops mem_req on that edge; the instruction is discarded.
- FSM states: IDLE, ACCESS, AMO_RD, AMO_WR.
- Non-memory instruction: registered to wb_out next edge (1-cycle latency); stall_o=0.
- Load/store from IDLE: mem_req asserts combinationally in the same cycle.
  - stall_o = mem_req & ~mem_ack.
  - The FSM moves to ACCESS while ack is absent.
  - Address, data and mask are held stable until ack.
  - The instruction is registered to wb_out on the ack edge; latency is 1 + wait cycles.
- Store mask/data:
  - Byte: mask = 1<<addr[1:0], rs2[7:0] replicated.
  - Half: mask = 0011 or 1100 by addr[1]; addr[0] ignored.
  - Word: mask = 1111; addr[1:0] ignored.
- Load data: select the lane by addr, then sign- or zero-extend per funct3. Result goes to lsu_rdata.
- Non-LR/SC AMO: AMO_RD (word read) → capture old value → AMO_WR.
  - Write f(old, rs2) with mask 1111 → complete.
  - rd receives the old value.
  - MIN/MAX compare signed; MINU/MAXU compare unsigned.
  - stall_o stays high until the AMO_WR ack.
- LR.W: word read; sets reservation {valid, addr[31:2]}; rd receives the read data.
- SC.W with the reservation valid and the address matching: word write of rs2; rd=0.
- SC.W otherwise: no bus access, completes in 1 cycle; rd=1.
- Reservation: SC clears it regardless of outcome. Any completed store or AMO write to the reserved word also clears it.
- wb_out fields for atomic writes: amo_mem_wr_req=1 for an AMO write or successful SC. mask, core_out_mem_addr_in and core_out_mem_data_in echo the write; all three are 0 for other instructions.
- Cycles with no completing instruction register a bubble: rf_en=0, amo_mem_wr_req=0.
- flush: honoured only while stall_o=0; the registered entry becomes a bubble and no bus request issues.
  - flush while stall_o=1 is ignored; the hazard unit never drives it then.
- ex_mem_rd and ex_mem_wr are never both high; ex_amo overrides both.

Test Plan:
- ALU op: opr_res=0x1234, rd=5, rf_en=1 → wb_out next cycle carries opr_res=0x1234, rd=5, rf_en=1; stall_o stays 0.
- LB at addr 0x103, mem_rdata=0x80FF_FF7F, ack after 2 waits → stall_o high 2 cycles; lsu_rdata=0xFFFF_FF80 one cycle after ack.
- SH rs2=0xABCD at addr 0x202 → mem_addr=0x200, mask=1100, wdata=0xABCD_ABCD; rf_en=0 on writeback.
- AMOADD.W addr 0x40, memory 5, rs2=3 → read then write 8 with mask 1111; rd=5; amo_mem_wr_req=1, data_in=8.
- LR.W 0x80, then SC.W 0x80 → write occurs, rd=0. A second SC.W → no mem_req, rd=1. LR, then SW to 0x80, then SC → rd=1.
- rst asserted during AMO_RD wait → next cycle mem_req=0, FSM IDLE, wb_out rf_en=0, reservation cleared.
